// File: rtl/morph3x3_if.sv
// Streaming pixel bus for morph3x3: raster input with start-of-frame marker,
// and a binary erode/dilate result stream with centre coordinates and frame statistics.
interface morph3x3_if #(
  parameter int PIX_W = 8
);
  logic             mode;
  logic             in_valid;
  logic             in_sof;
  logic [PIX_W-1:0] in_pixel;
  logic             out_valid;
  logic [PIX_W-1:0] out_pixel;
  logic [10:0]      out_x;
  logic [9:0]       out_y;
  logic             frame_done;
  logic [20:0]      set_count;

  modport master (
    output mode, in_valid, in_sof, in_pixel,
    input  out_valid, out_pixel, out_x, out_y, frame_done, set_count
  );

  modport slave (
    input  mode, in_valid, in_sof, in_pixel,
    output out_valid, out_pixel, out_x, out_y, frame_done, set_count
  );
endinterface

// File: rtl/morph3x3.sv
// 3x3 binary erode/dilate over a raster pixel stream, using two 1-bit line buffers
// and a column-shift window; emits one result per interior centre, one cycle after its last input.
module morph3x3 #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int PIX_W  = 8,
  parameter int THRESH = 0
) (
  input  logic       clk,
  input  logic       reset,
  morph3x3_if.slave  bus
);
  localparam int               XI = $clog2(IMG_W);
  localparam logic [PIX_W-1:0] TH = PIX_W'(THRESH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [10:0]      x_q;
  logic [9:0]       y_q;
  logic [IMG_W-1:0] lb1_q, lb2_q;
  logic [2:0]       col_a_q, col_b_q;
  logic             mode_q;
  logic             last_q;
  logic [20:0]      run_cnt_q;

  logic             sof, proc, eol, eof, emit, pix_bit, res;
  logic [10:0]      px;
  logic [9:0]       py;
  logic [XI-1:0]    pxi;
  logic [2:0]       col_new;
  logic [8:0]       win;

  // A sof pixel is processed as (0,0) in the same cycle, regardless of the current position.
  always_comb begin
    sof     = bus.in_valid & bus.in_sof;
    proc    = sof | (bus.in_valid & (state_q == RUN));
    px      = sof ? '0 : x_q;
    py      = sof ? '0 : y_q;
    pxi     = px[XI-1:0];
    eol     = (px == 11'(IMG_W - 1));
    eof     = eol && (py == 10'(IMG_H - 1));
    emit    = proc && (px >= 11'd2) && (py >= 10'd2);
    pix_bit = (bus.in_pixel > TH);
    col_new = {lb2_q[pxi], lb1_q[pxi], pix_bit};
    win     = {col_a_q, col_b_q, col_new};
    res     = mode_q ? (|win) : (&win);

    state_d = state_q;
    if (sof)
      state_d = RUN;
    else if (proc && eof)
      state_d = DONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q            <= '0;
      y_q            <= '0;
      lb1_q          <= '0;
      lb2_q          <= '0;
      col_a_q        <= '0;
      col_b_q        <= '0;
      mode_q         <= 1'b0;
      last_q         <= 1'b0;
      run_cnt_q      <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_pixel  <= '0;
      bus.out_x      <= '0;
      bus.out_y      <= '0;
      bus.frame_done <= 1'b0;
      bus.set_count  <= '0;
    end else begin
      bus.out_valid  <= 1'b0;
      bus.frame_done <= last_q;
      last_q         <= 1'b0;
      if (last_q)
        bus.set_count <= run_cnt_q;

      if (proc) begin
        // Window columns only feed results for x>=2, so columns left over from
        // the previous line are always shifted out before they are used.
        lb1_q[pxi] <= pix_bit;
        lb2_q[pxi] <= lb1_q[pxi];
        col_a_q    <= col_b_q;
        col_b_q    <= col_new;
        x_q        <= eol ? '0 : px + 11'd1;
        y_q        <= eof ? '0 : (eol ? py + 10'd1 : py);
        last_q     <= eof;

        if (sof) begin
          mode_q    <= bus.mode;
          run_cnt_q <= '0;
        end else if (emit) begin
          run_cnt_q <= run_cnt_q + 21'(res);
        end

        bus.out_valid <= emit;
        if (emit) begin
          bus.out_pixel <= {PIX_W{res}};
          bus.out_x     <= px - 11'd1;
          bus.out_y     <= py - 10'd1;
        end
      end
    end
  end
endmodule
